// File: rtl/mult_err_profiler.sv
// mult_err_profiler: exhaustive error sweep of a W x W approximate multiplier against an exact shift-add reference
// Ports: clk, rst_n (async, active low), start (begin sweep from IDLE/DONE),
//        a_o/b_o operands to the multiplier under test, y_i its combinational product,
//        busy/done sweep status, err_count/sum_abs_err/max_abs_err error statistics.
module mult_err_profiler #(
    parameter int W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [W-1:0]     a_o,
    output logic [W-1:0]     b_o,
    input  logic [2*W-1:0]   y_i,
    output logic             busy,
    output logic             done,
    output logic [2*W:0]     err_count,
    output logic [4*W-1:0]   sum_abs_err,
    output logic [2*W-1:0]   max_abs_err
);
    localparam int CW = $clog2(W + 1);
    localparam logic [W-1:0] MAX = '1;
    typedef enum logic [2:0] {IDLE, APPLY, MUL, CMP, DONE} state_t;
    state_t         state;
    logic [2*W-1:0] mcand, prod, d;
    logic [W-1:0]   mplier;
    logic [CW-1:0]  cnt;
    always_comb d = (y_i >= prod) ? y_i - prod : prod - y_i;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            a_o         <= '0;
            b_o         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err_count   <= '0;
            sum_abs_err <= '0;
            max_abs_err <= '0;
            mcand       <= '0;
            mplier      <= '0;
            prod        <= '0;
            cnt         <= '0;
        end else begin
            case (state)
                IDLE, DONE: if (start) begin
                    state       <= APPLY;
                    a_o         <= '0;
                    b_o         <= '0;
                    busy        <= 1'b1;
                    done        <= 1'b0;
                    err_count   <= '0;
                    sum_abs_err <= '0;
                    max_abs_err <= '0;
                end
                APPLY: begin
                    mcand  <= {{W{1'b0}}, a_o};
                    mplier <= b_o;
                    prod   <= '0;
                    cnt    <= '0;
                    state  <= MUL;
                end
                MUL: begin
                    if (mplier[0]) prod <= prod + mcand;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (cnt == CW'(W - 1)) state <= CMP;
                end
                CMP: begin
                    if (d != '0) err_count <= err_count + 1'b1;
                    sum_abs_err <= sum_abs_err + {{2*W{1'b0}}, d};
                    if (d > max_abs_err) max_abs_err <= d;
                    if (a_o == MAX && b_o == MAX) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        b_o   <= b_o + 1'b1;
                        if (b_o == MAX) a_o <= a_o + 1'b1;
                        state <= APPLY;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mult_err_profiler.sv
// tb_mult_err_profiler: directed sweeps of a W=4 profiler against selectable multiplier models
module tb_mult_err_profiler;
    localparam int W = 4;
    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic [W-1:0]   a_o, b_o;
    logic [2*W-1:0] y_i, p;
    logic           busy, done;
    logic [2*W:0]   err_count;
    logic [4*W-1:0] sum_abs_err;
    logic [2*W-1:0] max_abs_err;
    logic [1:0]     mode = 2'd0;
    int             n_chk = 0;
    int             n_fail = 0;
    int             cyc;
    typedef struct {logic [1:0] m; logic [31:0] ee, es, em;} vec_t;
    vec_t vec[4];
    mult_err_profiler #(.W(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a_o(a_o), .b_o(b_o), .y_i(y_i),
        .busy(busy), .done(done), .err_count(err_count), .sum_abs_err(sum_abs_err),
        .max_abs_err(max_abs_err)
    );
    always #5 clk = ~clk;
    // 0 exact, 1 tied zero, 2 exact+1, 3 exact with bit 0 forced low
    assign p = a_o * b_o;
    always_comb y_i = mode == 2'd0 ? p : mode == 2'd1 ? '0 : mode == 2'd2 ? p + 8'd1 : {p[7:1], 1'b0};
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask
    task automatic kick(input logic [1:0] m);
        mode = m;
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        chk("clr_stats", {err_count, sum_abs_err, max_abs_err}, 0);
        chk("clr_pair", {a_o, b_o}, 0);
        chk("start_busy", busy, 1);
        chk("start_done", done, 0);
    endtask
    task automatic finish_run(input int c0, input logic [31:0] ee, es, em);
        int c = c0;
        while (!done && c < 3000) begin
            step(1);
            c++;
        end
        chk("sweep_cycles", c, 1536);
        chk("end_busy", busy, 0);
        chk("end_done", done, 1);
        chk("last_pair", {a_o, b_o}, 8'hFF);
        chk("err_count", err_count, ee);
        chk("sum_abs_err", sum_abs_err, es);
        chk("max_abs_err", max_abs_err, em);
    endtask
    initial begin
        vec[0] = '{2'd1, 225, 14400, 225};
        vec[1] = '{2'd0, 0, 0, 0};
        vec[2] = '{2'd2, 256, 256, 1};
        vec[3] = '{2'd3, 64, 64, 1};
        #12;
        chk("rst_outputs", {a_o, b_o, busy, done, err_count, sum_abs_err, max_abs_err}, 0);
        @(negedge clk) rst_n = 1'b1;
        step(3);
        chk("idle_hold", {busy, done}, 0);
        for (int i = 0; i < 4; i++) begin
            kick(vec[i].m);
            finish_run(0, vec[i].ee, vec[i].es, vec[i].em);
        end
        kick(2'd0);
        step(5);
        chk("pair0_hold", {a_o, b_o}, 8'h00);
        step(1);
        chk("pair1", {a_o, b_o}, 8'h01);
        step(89);
        chk("pair_0_15", {a_o, b_o}, 8'h0F);
        step(1);
        chk("pair_wrap", {a_o, b_o}, 8'h10);
        step(3);
        start = 1'b1;
        step(1);
        start = 1'b0;
        cyc = 100;
        chk("busy_start_busy", busy, 1);
        chk("busy_start_pair", {a_o, b_o}, 8'h10);
        step(2);
        cyc = 102;
        chk("busy_start_stats", {err_count, sum_abs_err, max_abs_err}, 0);
        finish_run(cyc, 0, 0, 0);
        kick(2'd1);
        step(300);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_outputs", {a_o, b_o, busy, done, err_count, sum_abs_err, max_abs_err}, 0);
        step(2);
        chk("abort_hold", {a_o, b_o, busy, done, err_count, sum_abs_err, max_abs_err}, 0);
        @(negedge clk) rst_n = 1'b1;
        kick(2'd0);
        finish_run(0, 0, 0, 0);
        kick(2'd1);
        finish_run(0, 225, 14400, 225);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/mult_err_profiler.md
Name: mult_err_profiler

Overview:
Synthesizable on-chip characterization engine for the approximate recursive multipliers. It sweeps every operand pair (a, b) into a combinational approximate multiplier under test and captures that multiplier's product. It computes the exact product with an internal shift-add unit and accumulates error statistics: mismatch count, sum of absolute error and maximum absolute error. It is the hardware counterpart to exhaustive simulation sweeps and sits beside any W x W approximate multiplier instance.

Parameters:
W, 8, operand width; the sweep covers 2^(2W) pairs.

Ports:
clk  input  1  clock, rising-edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  begin a sweep; sampled only in IDLE or DONE.
a_o  output  W  operand a driven to the multiplier under test.
b_o  output  W  operand b driven to the multiplier under test.
y_i  input  2W  approximate product returned combinationally by the multiplier under test.
busy  output  1  high while a sweep is in progress.
done  output  1  high from sweep completion until the next start or reset.
err_count  output  2W+1  number of pairs with y_i != a*b.
sum_abs_err  output  4W  sum of |y_i - a*b| over all pairs.
max_abs_err  output  2W  largest |y_i - a*b| seen.

Behaviour:
- Reset (async, rst_n=0): state IDLE; a_o, b_o, busy, done, err_count, sum_abs_err and max_abs_err all 0; internal accumulator cleared.
- FSM states: IDLE, APPLY, MUL, CMP, DONE.
- IDLE/DONE: start=1 -> APPLY; err_count, sum_abs_err, max_abs_err, a_o and b_o cleared; done=0; busy=1 from the next cycle. start=0 -> remain in state.
- APPLY (1 cycle): a_o/b_o hold the current pair; load the multiplicand and multiplier copies and clear the product accumulator -> MUL.
- MUL (exactly W cycles): LSB-first shift-add; product exact after the W-th cycle -> CMP.
- CMP (1 cycle): sample y_i (a_o/b_o stable for W+1 cycles before this) and compute d = |y_i - exact| in 2W bits.
  - d != 0 -> err_count += 1.
  - sum_abs_err += d.
  - d > max_abs_err -> max_abs_err = d.
  - Advance the pair: b_o increments; when b_o = 2^W-1 it wraps to 0 and a_o increments.
  - If a_o = b_o = 2^W-1 (last pair) -> DONE with busy=0, done=1, and a_o/b_o hold the last pair. Otherwise -> APPLY.
- Pair cadence is W+2 cycles; a full sweep is 2^(2W)*(W+2) cycles from the first APPLY to the DONE entry.
- Order is a outer loop, b inner loop: (0,0), (0,1), ..., (0,2^W-1), (1,0), ...
- Widths are sized so no overflow can occur: err_count max 2^(2W); sum_abs_err < 2^(4W).
- start while busy: ignored, with no effect on the sweep.
- Reset mid-sweep: immediate abort to reset values; a later start begins a fresh sweep from (0,0).
- Outputs are registered; statistics are valid (final) only while done=1.

Test Plan:
- W=4, y_i = a_o*b_o (exact model); pulse start -> busy falls and done rises 1536 cycles after APPLY entry; err_count=0, sum_abs_err=0, max_abs_err=0.
- W=4, y_i tied 0 -> err_count=225, sum_abs_err=14400, max_abs_err=225.
- W=4, y_i = a_o*b_o+1 -> err_count=256, sum_abs_err=256, max_abs_err=1.
- W=8, y_i = exact product with bit 0 forced 0 -> err_count=16384 (odd*odd pairs), sum_abs_err=16384, max_abs_err=1; sweep takes 655360 cycles.
- W=4: pulse start, check a_o/b_o sequence (0,0)->(0,1) after 6 cycles and (0,15)->(1,0) wrap; pulse start again at cycle 100 -> no change to sequence or results.
- W=4: assert rst_n=0 mid-sweep -> all outputs 0 immediately; start again -> full correct results as in the exact-model case; start from DONE clears stats and reruns.
